// File: rtl/ped_crossing_ctrl_pkg.sv
// Shared types and constants for the pedestrian-crossing responder.
// State encodings and lamp polarity match the traffic light controller.
package ped_crossing_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQUEST = 3'd1,
        ST_WALK    = 3'd2,
        ST_FLASH   = 3'd3,
        ST_CLEAR   = 3'd4
    } ped_state_e;

    localparam logic LAMP_ON  = 1'b1;
    localparam logic LAMP_OFF = 1'b0;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ped_crossing_ctrl_debounce.sv
// Walk-button synchronizer and debounce counter.
// Emits a single-cycle press pulse per distinct debounced press.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic button,
    output logic press
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_HIT = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0] DB_ONE = DB_W'(1);

    logic            sync_q1;
    logic            sync_q2;
    logic [DB_W-1:0] db_cnt;
    logic [1:0]      primed;
    logic            lockout;

    // A button already held at reset is locked out until the synchronized
    // path shows a genuine low sample, so it cannot masquerade as a new press.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            db_cnt  <= '0;
            press   <= 1'b0;
            primed  <= '0;
            lockout <= button;
        end else begin
            sync_q1 <= button;
            sync_q2 <= sync_q1;
            primed  <= {primed[0], 1'b1};
            press   <= 1'b0;
            if (primed[1] && !sync_q2) begin
                lockout <= 1'b0;
            end
            if (!sync_q2) begin
                db_cnt <= '0;
            end else if (db_cnt != DB_MAX) begin
                db_cnt <= db_cnt + DB_ONE;
                press  <= (db_cnt == DB_HIT) && !lockout;
            end
        end
    end

endmodule

// File: rtl/ped_crossing_ctrl.sv
// Pedestrian-crossing responder: request, walk/flash sequencing and
// completion handshake towards the traffic light controller.
module ped_crossing_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned WALK_CYCLES     = 8,
    parameter int unsigned FLASH_CYCLES    = 6,
    parameter int unsigned CNT_W           = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             button,
    input  logic             grant,
    output logic             req,
    output logic             done,
    output logic             walk,
    output logic             dont_walk,
    output logic [CNT_W-1:0] count
);

    import ped_crossing_ctrl_pkg::*;

    if (((1 << CNT_W) - 1) < max_u(WALK_CYCLES, FLASH_CYCLES)) begin : g_cnt_w_check
        $error("CNT_W too narrow to hold WALK_CYCLES/FLASH_CYCLES");
    end

    localparam logic [CNT_W-1:0] WALK_LOAD  = CNT_W'(WALK_CYCLES);
    localparam logic [CNT_W-1:0] FLASH_LOAD = CNT_W'(FLASH_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    ped_state_e state;
    logic       pending;
    logic       press;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk   (clk),
        .reset (reset),
        .button(button),
        .press (press)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            req       <= 1'b0;
            done      <= 1'b0;
            walk      <= LAMP_OFF;
            dont_walk <= LAMP_ON;
            count     <= '0;
            pending   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (press || pending) begin
                        state   <= ST_REQUEST;
                        req     <= 1'b1;
                        pending <= 1'b0;
                    end
                end
                ST_REQUEST: begin
                    if (grant) begin
                        state     <= ST_WALK;
                        req       <= 1'b0;
                        walk      <= LAMP_ON;
                        dont_walk <= LAMP_OFF;
                        count     <= WALK_LOAD;
                    end
                end
                ST_WALK: begin
                    if (press) pending <= 1'b1;
                    if (!grant) begin
                        state     <= ST_CLEAR;
                        walk      <= LAMP_OFF;
                        dont_walk <= LAMP_ON;
                        count     <= '0;
                        done      <= 1'b1;
                    end else if (count == CNT_ONE) begin
                        state     <= ST_FLASH;
                        walk      <= LAMP_OFF;
                        dont_walk <= LAMP_ON;
                        count     <= FLASH_LOAD;
                    end else begin
                        count <= count - CNT_ONE;
                    end
                end
                ST_FLASH: begin
                    if (press) pending <= 1'b1;
                    // Abort and normal completion land in the same CLEAR entry.
                    if (!grant || count == CNT_ONE) begin
                        state     <= ST_CLEAR;
                        walk      <= LAMP_OFF;
                        dont_walk <= LAMP_ON;
                        count     <= '0;
                        done      <= 1'b1;
                    end else begin
                        count     <= count - CNT_ONE;
                        dont_walk <= ~dont_walk;
                    end
                end
                ST_CLEAR: begin
                    if (press) pending <= 1'b1;
                    dont_walk <= LAMP_ON;
                    if (!grant) state <= ST_IDLE;
                end
                default: begin
                    state     <= ST_IDLE;
                    req       <= 1'b0;
                    walk      <= LAMP_OFF;
                    dont_walk <= LAMP_ON;
                    count     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Self-checking bench for ped_crossing_ctrl: directed scenarios plus random
// button/grant traffic compared against a sequence-level reference model.
module tb_ped_crossing_ctrl;

    localparam int D = 4;
    localparam int W = 8;
    localparam int F = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       button = 1'b0;
    logic       grant = 1'b0;
    logic       req;
    logic       done;
    logic       walk;
    logic       dont_walk;
    logic [3:0] count;

    int n_checks = 0;
    int n_errors = 0;

    // reference model: button run lengths and crossing progress as a step index
    int m_raw, m_rl1, m_rl2;
    bit m_press, m_lock;
    bit m_requesting, m_clearing, m_done_due, m_queued;
    int m_step;

    ped_crossing_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .WALK_CYCLES    (W),
        .FLASH_CYCLES   (F),
        .CNT_W          (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .button   (button),
        .grant    (grant),
        .req      (req),
        .done     (done),
        .walk     (walk),
        .dont_walk(dont_walk),
        .count    (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, input bit b, input bit g);
        bit p;
        if (r) begin
            m_raw = 0; m_rl1 = -1; m_rl2 = -1;
            m_press = 0; m_lock = b;
            m_requesting = 0; m_clearing = 0; m_done_due = 0; m_queued = 0;
            m_step = -1;
            return;
        end
        p = m_press;
        m_press = (m_rl2 == D) && !m_lock;
        if (m_rl2 == 0) m_lock = 0;
        m_rl2 = m_rl1;
        m_raw = b ? ((m_raw < 100) ? m_raw + 1 : 100) : 0;
        m_rl1 = m_raw;

        m_done_due = 0;
        if (m_requesting) begin
            if (g) begin
                m_requesting = 0;
                m_step = 0;
            end
        end else if (m_step >= 0) begin
            if (p) m_queued = 1;
            if (!g || m_step + 1 == W + F) begin
                m_step = -1;
                m_clearing = 1;
                m_done_due = 1;
            end else begin
                m_step++;
            end
        end else if (m_clearing) begin
            if (p) m_queued = 1;
            if (!g) m_clearing = 0;
        end else if (p || m_queued) begin
            m_requesting = 1;
            m_queued = 0;
        end
    endtask

    task automatic compare_outputs();
        bit e_walk, e_dw;
        int e_cnt;
        e_walk = (m_step >= 0) && (m_step < W);
        e_dw = !e_walk && !((m_step >= W) && (((m_step - W) % 2) == 1));
        e_cnt = (m_step < 0) ? 0 : (m_step < W) ? (W - m_step) : (W + F - m_step);
        check("req", req, m_requesting);
        check("done", done, m_done_due);
        check("walk", walk, e_walk);
        check("dont_walk", dont_walk, e_dw);
        check("count", count, e_cnt);
    endtask

    task automatic step(input bit r, input bit b, input bit g);
        reset = r; button = b; grant = g;
        @(posedge clk);
        model_edge(r, b, g);
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic run(input int n, input bit r, input bit b, input bit g);
        for (int i = 0; i < n; i++) step(r, b, g);
    endtask

    initial begin
        int hold;
        bit b, g;
        @(negedge clk);

        // 1: debounced press raises req after edge D+3
        run(2, 1, 0, 0);
        check("rst_req", req, 0);
        check("rst_dw", dont_walk, 1);
        check("rst_count", count, 0);
        for (int i = 1; i <= 10; i++) begin
            step(0, 1, 0);
            check("t1_req", req, (i >= 7) ? 1 : 0);
        end
        check("t1_walk", walk, 0);

        // 2: full walk / flash / done sequence
        for (int i = 0; i < W; i++) begin
            step(0, 0, 1);
            check("t2_walk", walk, 1);
            check("t2_wcount", count, W - i);
        end
        for (int i = 0; i < F; i++) begin
            step(0, 0, 1);
            check("t2_fdw", dont_walk, (i % 2 == 0) ? 1 : 0);
            check("t2_fcount", count, F - i);
        end
        step(0, 0, 1);
        check("t2_done", done, 1);
        step(0, 0, 1);
        check("t2_done_pulse", done, 0);
        step(0, 0, 0);

        // 3: short glitches are filtered, a 4-cycle burst is a press
        for (int n = 1; n <= 3; n++) begin
            run(n, 0, 1, 0);
            run(6, 0, 0, 0);
            check("t3_glitch", req, 0);
        end
        run(4, 0, 1, 0);
        run(4, 0, 0, 0);
        check("t3_burst", req, 1);

        // 4: press during WALK is queued and re-requests after IDLE
        run(5, 0, 1, 1);
        run(20, 0, 0, 1);
        step(0, 0, 0);
        check("t4_idle", req, 0);
        step(0, 0, 0);
        check("t4_queued", req, 1);

        // 5: grant dropped at WALK count 5 aborts to CLEAR
        run(4, 0, 0, 1);
        check("t5_count", count, 5);
        step(0, 0, 0);
        check("t5_walk", walk, 0);
        check("t5_dw", dont_walk, 1);
        check("t5_done", done, 1);
        check("t5_cnt0", count, 0);
        step(0, 0, 0);
        check("t5_done_off", done, 0);

        // 6: reset mid-FLASH with button held; needs release and re-press
        run(5, 0, 1, 0);
        run(3, 0, 0, 0);
        run(10, 0, 0, 1);
        run(3, 0, 1, 1);
        step(1, 1, 1);
        check("t6_rst_walk", walk, 0);
        check("t6_rst_dw", dont_walk, 1);
        check("t6_rst_cnt", count, 0);
        run(12, 0, 1, 0);
        check("t6_held", req, 0);
        run(3, 0, 0, 0);
        run(4, 0, 1, 0);
        run(4, 0, 0, 0);
        check("t6_repress", req, 1);

        // random traffic
        hold = 0; b = 0; g = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                b = ~b;
                hold = $urandom_range(1, 8);
            end
            hold--;
            if (m_requesting && ($urandom_range(0, 2) == 0)) g = 1;
            else if (g && m_clearing && ($urandom_range(0, 1) == 0)) g = 0;
            else if (g && m_step >= 0 && ($urandom_range(0, 24) == 0)) g = 0;
            step($urandom_range(0, 299) == 0, b, g);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
